// File: rtl/dcp_noc2fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dcp_noc2fifo_pkg
// Purpose : Field widths, packed-entry layout and shared constants for the
//           DCP NoC2 request FIFO. Field-width macros default to the DCP
//           values when dcp.h has not already defined them.
// Ports   : none (package)
// Config  : DCP_NOC2FIFO_BYPASS_EN (consumed by dcp_noc2fifo)
// Rev     : 1.0 - initial release
// ============================================================================

`ifndef DCP_NOC2_REQTYPE_WIDTH
`define DCP_NOC2_REQTYPE_WIDTH 5
`endif
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef DCP_MSHRID_WIDTH
`define DCP_MSHRID_WIDTH 5
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif
`ifndef PACKET_HOME_ID_WIDTH
`define PACKET_HOME_ID_WIDTH 30
`endif
`ifndef MSG_SRC_FBITS_WIDTH
`define MSG_SRC_FBITS_WIDTH 4
`endif

// Entry layout, LSB first: fbits | homeid | address | mshrid | data | type
`define DCP_NOC2FIFO_FBITS_OFF   0
`define DCP_NOC2FIFO_HOMEID_OFF  (`DCP_NOC2FIFO_FBITS_OFF   + `MSG_SRC_FBITS_WIDTH)
`define DCP_NOC2FIFO_ADDR_OFF    (`DCP_NOC2FIFO_HOMEID_OFF  + `PACKET_HOME_ID_WIDTH)
`define DCP_NOC2FIFO_MSHRID_OFF  (`DCP_NOC2FIFO_ADDR_OFF    + `PHY_ADDR_WIDTH)
`define DCP_NOC2FIFO_DATA_OFF    (`DCP_NOC2FIFO_MSHRID_OFF  + `DCP_MSHRID_WIDTH)
`define DCP_NOC2FIFO_TYPE_OFF    (`DCP_NOC2FIFO_DATA_OFF    + `NOC_DATA_WIDTH)
`define DCP_NOC2FIFO_ENTRY_WIDTH (`DCP_NOC2FIFO_TYPE_OFF    + `DCP_NOC2_REQTYPE_WIDTH)

package dcp_noc2fifo_pkg;
  localparam int C_TYPE_W   = `DCP_NOC2_REQTYPE_WIDTH;
  localparam int C_DATA_W   = `NOC_DATA_WIDTH;
  localparam int C_MSHRID_W = `DCP_MSHRID_WIDTH;
  localparam int C_ADDR_W   = `PHY_ADDR_WIDTH;
  localparam int C_HOMEID_W = `PACKET_HOME_ID_WIDTH;
  localparam int C_FBITS_W  = `MSG_SRC_FBITS_WIDTH;
  localparam int C_ENTRY_W  = `DCP_NOC2FIFO_ENTRY_WIDTH;
endpackage

`default_nettype wire

// File: rtl/dcp_noc2fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : dcp_noc2fifo_mem
// Purpose : DEPTH x WIDTH register array with one write port and one
//           asynchronous read port. All entries reset to zero.
// Ports   : clk, rst_n           - clock, async active-low reset
//           we, waddr, wdata     - write port
//           raddr, rdata         - combinational read port
// Rev     : 1.0 - initial release
// ============================================================================
module dcp_noc2fifo_mem
  import dcp_noc2fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = C_ENTRY_W,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] rd_vec [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [WIDTH-1:0] entry_d;
      logic [WIDTH-1:0] entry_q;

      always_comb begin
        entry_d = entry_q;
        if (we && (waddr == PTR_W'(i))) begin
          entry_d = wdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign rd_vec[i] = entry_q;
    end
  endgenerate

  // raddr is always < DEPTH, so the unused codes of a non-power-of-2 depth
  // are never selected.
  assign rdata = rd_vec[raddr];

endmodule
`default_nettype wire

// File: rtl/dcp_noc2fifo.sv
`default_nettype none
// ============================================================================
// Module  : dcp_noc2fifo
// Purpose : DEPTH-entry in-order FIFO between the DCP request generator and
//           the NoC2 encoder, using the val/ack handshake on both sides, with
//           occupancy and almost-full reporting for prefetch throttling.
// Ports   : clk, rst_n                      - clock, async active-low reset
//           noc2buffer_*  (in)              - producer request + val
//           noc2buffer_ack (out)            - request accepted this cycle
//           noc2buffer_noc2encoder_* (out)  - head entry + val
//           noc2encoder_noc2buffer_ack (in) - encoder consumed head
//           noc2fifo_count, noc2fifo_almost_full - occupancy reporting
// Config  : DCP_NOC2FIFO_BYPASS_EN - zero-latency pass-through when empty
// Rev     : 1.0 - initial release
// ============================================================================
module dcp_noc2fifo
  import dcp_noc2fifo_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  noc2buffer_val,
  input  logic [C_TYPE_W-1:0]   noc2buffer_type,
  input  logic [C_DATA_W-1:0]   noc2buffer_data,
  input  logic [C_MSHRID_W-1:0] noc2buffer_mshrid,
  input  logic [C_ADDR_W-1:0]   noc2buffer_address,
  input  logic [C_HOMEID_W-1:0] noc2buffer_homeid,
  input  logic [C_FBITS_W-1:0]  noc2buffer_fbits,
  output logic                  noc2buffer_ack,
  output logic                  noc2buffer_noc2encoder_val,
  output logic [C_TYPE_W-1:0]   noc2buffer_noc2encoder_type,
  output logic [C_DATA_W-1:0]   noc2buffer_noc2encoder_data,
  output logic [C_MSHRID_W-1:0] noc2buffer_noc2encoder_mshrid,
  output logic [C_ADDR_W-1:0]   noc2buffer_noc2encoder_address,
  output logic [C_HOMEID_W-1:0] noc2buffer_noc2encoder_homeid,
  output logic [C_FBITS_W-1:0]  noc2buffer_noc2encoder_fbits,
  input  logic                  noc2encoder_noc2buffer_ack,
  output logic [CNT_W-1:0]      noc2fifo_count,
  output logic                  noc2fifo_almost_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]     rd_ptr_d, rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_d, wr_ptr_q;
  logic [CNT_W-1:0]     count_d,  count_q;
  logic                 pop, push, wr_en, bypass_take, bypass_active, empty;
  logic [C_ENTRY_W-1:0] wdata, rdata;

  assign empty = (count_q == '0);
  assign pop   = noc2encoder_noc2buffer_ack && !empty;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  // Gated by rst_n so no handshake completes while reset is held.
  assign noc2buffer_ack = rst_n && noc2buffer_val &&
                          ((count_q < CNT_W'(DEPTH)) || pop);
  assign push = noc2buffer_ack;

`ifdef DCP_NOC2FIFO_BYPASS_EN
  // Empty FIFO forwards the request straight through; if the encoder takes
  // it in the same cycle there is nothing left to store.
  assign bypass_active = rst_n && empty && noc2buffer_val;
  assign bypass_take   = bypass_active && noc2encoder_noc2buffer_ack;
`else
  assign bypass_active = 1'b0;
  assign bypass_take   = 1'b0;
`endif

  assign wr_en = push && !bypass_take;

  assign wdata = {noc2buffer_type, noc2buffer_data, noc2buffer_mshrid,
                  noc2buffer_address, noc2buffer_homeid, noc2buffer_fbits};

  // Explicit wrap compare keeps non-power-of-2 depths correct.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  dcp_noc2fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (C_ENTRY_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    noc2buffer_noc2encoder_val     = !empty;
    noc2buffer_noc2encoder_type    = rdata[`DCP_NOC2FIFO_TYPE_OFF   +: C_TYPE_W];
    noc2buffer_noc2encoder_data    = rdata[`DCP_NOC2FIFO_DATA_OFF   +: C_DATA_W];
    noc2buffer_noc2encoder_mshrid  = rdata[`DCP_NOC2FIFO_MSHRID_OFF +: C_MSHRID_W];
    noc2buffer_noc2encoder_address = rdata[`DCP_NOC2FIFO_ADDR_OFF   +: C_ADDR_W];
    noc2buffer_noc2encoder_homeid  = rdata[`DCP_NOC2FIFO_HOMEID_OFF +: C_HOMEID_W];
    noc2buffer_noc2encoder_fbits   = rdata[`DCP_NOC2FIFO_FBITS_OFF  +: C_FBITS_W];
    if (bypass_active) begin
      noc2buffer_noc2encoder_val     = 1'b1;
      noc2buffer_noc2encoder_type    = noc2buffer_type;
      noc2buffer_noc2encoder_data    = noc2buffer_data;
      noc2buffer_noc2encoder_mshrid  = noc2buffer_mshrid;
      noc2buffer_noc2encoder_address = noc2buffer_address;
      noc2buffer_noc2encoder_homeid  = noc2buffer_homeid;
      noc2buffer_noc2encoder_fbits   = noc2buffer_fbits;
    end
  end

  assign noc2fifo_count       = count_q;
  // Derived only from the count register: no path from the inputs.
  assign noc2fifo_almost_full = (count_q >= CNT_W'(AFULL_LEVEL));

endmodule
`default_nettype wire

// File: tb/tb_dcp_noc2fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcp_noc2fifo
// Purpose : Directed self-checking bench for dcp_noc2fifo. Instance a_dut is
//           DEPTH=4 (fill, full+pop, drain order, empty ack, reset, bypass);
//           instance b_dut is DEPTH=3 (pointer wrap with interleaved traffic).
// Config  : DCP_NOC2FIFO_BYPASS_EN selects the expected bypass behaviour.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_dcp_noc2fifo;
  import dcp_noc2fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DEPTH=4 instance ----------------
  logic                  a_val = 1'b0, a_enc_ack = 1'b0, a_ack, a_out_val, a_afull;
  logic [C_TYPE_W-1:0]   a_type = '0,  a_o_type;
  logic [C_DATA_W-1:0]   a_data = '0,  a_o_data;
  logic [C_MSHRID_W-1:0] a_mshr = '0,  a_o_mshr;
  logic [C_ADDR_W-1:0]   a_addr = '0,  a_o_addr;
  logic [C_HOMEID_W-1:0] a_home = '0,  a_o_home;
  logic [C_FBITS_W-1:0]  a_fbits = '0, a_o_fbits;
  logic [2:0]            a_count;

  dcp_noc2fifo #(.DEPTH(4)) a_dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .noc2buffer_val                 (a_val),
    .noc2buffer_type                (a_type),
    .noc2buffer_data                (a_data),
    .noc2buffer_mshrid              (a_mshr),
    .noc2buffer_address             (a_addr),
    .noc2buffer_homeid              (a_home),
    .noc2buffer_fbits               (a_fbits),
    .noc2buffer_ack                 (a_ack),
    .noc2buffer_noc2encoder_val     (a_out_val),
    .noc2buffer_noc2encoder_type    (a_o_type),
    .noc2buffer_noc2encoder_data    (a_o_data),
    .noc2buffer_noc2encoder_mshrid  (a_o_mshr),
    .noc2buffer_noc2encoder_address (a_o_addr),
    .noc2buffer_noc2encoder_homeid  (a_o_home),
    .noc2buffer_noc2encoder_fbits   (a_o_fbits),
    .noc2encoder_noc2buffer_ack     (a_enc_ack),
    .noc2fifo_count                 (a_count),
    .noc2fifo_almost_full           (a_afull)
  );

  // ---------------- DEPTH=3 instance ----------------
  logic                  b_val = 1'b0, b_enc_ack = 1'b0, b_ack, b_out_val, b_afull;
  logic [C_TYPE_W-1:0]   b_o_type;
  logic [C_DATA_W-1:0]   b_data = '0, b_o_data;
  logic [C_MSHRID_W-1:0] b_o_mshr;
  logic [C_ADDR_W-1:0]   b_addr = '0, b_o_addr;
  logic [C_HOMEID_W-1:0] b_o_home;
  logic [C_FBITS_W-1:0]  b_o_fbits;
  logic [1:0]            b_count;

  dcp_noc2fifo #(.DEPTH(3)) b_dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .noc2buffer_val                 (b_val),
    .noc2buffer_type                ('0),
    .noc2buffer_data                (b_data),
    .noc2buffer_mshrid              ('0),
    .noc2buffer_address             (b_addr),
    .noc2buffer_homeid              ('0),
    .noc2buffer_fbits               ('0),
    .noc2buffer_ack                 (b_ack),
    .noc2buffer_noc2encoder_val     (b_out_val),
    .noc2buffer_noc2encoder_type    (b_o_type),
    .noc2buffer_noc2encoder_data    (b_o_data),
    .noc2buffer_noc2encoder_mshrid  (b_o_mshr),
    .noc2buffer_noc2encoder_address (b_o_addr),
    .noc2buffer_noc2encoder_homeid  (b_o_home),
    .noc2buffer_noc2encoder_fbits   (b_o_fbits),
    .noc2encoder_noc2buffer_ack     (b_enc_ack),
    .noc2fifo_count                 (b_count),
    .noc2fifo_almost_full           (b_afull)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request k of the DEPTH=4 sequence: address 0x100 + 0x40*k.
  task automatic set_a(input int k);
    a_addr  = C_ADDR_W'(32'h100 + 32'h40 * k);
    a_data  = C_DATA_W'(32'hD0 + k);
    a_type  = C_TYPE_W'(k + 1);
    a_mshr  = C_MSHRID_W'(k + 2);
    a_home  = C_HOMEID_W'(32'h10 + k);
    a_fbits = C_FBITS_W'(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt3 [10] = '{1, 2, 3, 3, 3, 3, 3, 2, 1, 0};

  initial begin
    // ---- reset then idle ----
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_val",   64'(a_out_val), 64'd0);
    chk("rst_count", 64'(a_count),   64'd0);
    chk("rst_afull", 64'(a_afull),   64'd0);
    chk("rst_ack",   64'(a_ack),     64'd0);
    chk("rst_addr",  64'(a_o_addr),  64'd0);
    chk("rst_data",  64'(a_o_data),  64'd0);
    chk("rst_type",  64'(a_o_type),  64'd0);
    chk("rst_home",  64'(a_o_home),  64'd0);
    tick();

    // ---- fill 4 entries, encoder not acking ----
    for (int i = 0; i < 4; i++) begin
      a_val = 1'b1;
      set_a(i);
      #1 chk("fill_ack", 64'(a_ack), 64'd1);
      tick();
      chk("fill_count", 64'(a_count),   64'(i + 1));
      chk("fill_afull", 64'(a_afull),   64'(i + 1 >= 3));
      chk("fill_val",   64'(a_out_val), 64'd1);
      chk("fill_head",  64'(a_o_addr),  64'h100);
    end

    // ---- 5th request held while full ----
    set_a(4);
    #1 chk("full_ack", 64'(a_ack), 64'd0);
    tick();
    chk("full_count", 64'(a_count), 64'd4);

    // ---- full: pop and push in the same cycle ----
    a_enc_ack = 1'b1;
    #1;
    chk("fullpop_ack",  64'(a_ack),    64'd1);
    chk("fullpop_head", 64'(a_o_addr), 64'h100);
    chk("fullpop_data", 64'(a_o_data), 64'hD0);
    chk("fullpop_mshr", 64'(a_o_mshr), 64'd2);
    tick();
    a_val = 1'b0;
    chk("fullpop_count", 64'(a_count), 64'd4);

    // ---- drain: order 0x140, 0x180, 0x1C0, 0x200 ----
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("drain_val",   64'(a_out_val), 64'd1);
      chk("drain_addr",  64'(a_o_addr),  64'(32'h100 + 32'h40 * k));
      chk("drain_data",  64'(a_o_data),  64'(32'hD0 + k));
      chk("drain_type",  64'(a_o_type),  64'(k + 1));
      chk("drain_home",  64'(a_o_home),  64'(32'h10 + k));
      chk("drain_fbits", 64'(a_o_fbits), 64'(k));
      tick();
      chk("drain_count", 64'(a_count), 64'(4 - k));
    end
    chk("drain_afull", 64'(a_afull),   64'd0);
    chk("drain_empty", 64'(a_out_val), 64'd0);

    // ---- encoder ack held while empty ----
    tick();
    tick();
    chk("emptyack_count", 64'(a_count),   64'd0);
    chk("emptyack_val",   64'(a_out_val), 64'd0);

    // ---- empty FIFO, request with encoder ack in the same cycle ----
    set_a(8);
    a_val = 1'b1;
    #1;
`ifdef DCP_NOC2FIFO_BYPASS_EN
    chk("byp_val",  64'(a_out_val), 64'd1);
    chk("byp_addr", 64'(a_o_addr),  64'h300);
    chk("byp_ack",  64'(a_ack),     64'd1);
    tick();
    a_val = 1'b0;
    #1 chk("byp_count", 64'(a_count), 64'd0);
`else
    chk("nobyp_val", 64'(a_out_val), 64'd0);
    chk("nobyp_ack", 64'(a_ack),     64'd1);
    tick();
    a_val = 1'b0;
    #1;
    chk("nobyp_count", 64'(a_count),  64'd1);
    chk("nobyp_head",  64'(a_o_addr), 64'h300);
    tick();
    chk("nobyp_pop", 64'(a_count), 64'd0);
`endif
    a_enc_ack = 1'b0;
    tick();

    // ---- DEPTH=3: 7 pushes/pops interleaved, pointers wrap ----
    for (int t = 0; t < 10; t++) begin
      b_val     = (t < 7);
      b_data    = 64'(32'hA00 + t + 1);
      b_addr    = C_ADDR_W'(t + 1);
      b_enc_ack = (t >= 3);
      #1;
      chk("d3_ack", 64'(b_ack), 64'(t < 7));
      if (t >= 3) begin
        chk("d3_order", 64'(b_o_data),  64'(32'hA00 + t - 2));
        chk("d3_val",   64'(b_out_val), 64'd1);
      end
      tick();
      chk("d3_count", 64'(b_count), 64'(exp_cnt3[t]));
    end
    b_val     = 1'b0;
    b_enc_ack = 1'b0;
    #1 chk("d3_empty", 64'(b_out_val), 64'd0);

    // ---- fill 2, then reset between clock edges ----
    a_val = 1'b1;
    set_a(5);
    tick();
    set_a(6);
    tick();
    a_val = 1'b0;
    chk("prerst_count", 64'(a_count), 64'd2);
    #2;
    a_val = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_val",   64'(a_out_val), 64'd0);
    chk("midrst_count", 64'(a_count),   64'd0);
    chk("midrst_afull", 64'(a_afull),   64'd0);
    chk("midrst_ack",   64'(a_ack),     64'd0);
    chk("midrst_addr",  64'(a_o_addr),  64'd0);
    tick();
    a_val = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("postrst_count", 64'(a_count),   64'd0);
    chk("postrst_val",   64'(a_out_val), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
